// File: rtl/mrd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mrd_pkg
// Description : Shared constants and types for the radix-2/3/4/5 write-back bank.
// Revision    : 1.0  initial release
// ============================================================================
package mrd_pkg;

    localparam int NUM_BANK = 5;
    localparam int wDATA    = 18;
    localparam int wADDR    = 8;
    localparam int wIDX     = 3;

    typedef struct packed {
        logic signed [wDATA-1:0] re;
        logic signed [wDATA-1:0] im;
    } bank_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mrd_bank_xbar.sv
`default_nettype none
// ============================================================================
// Module      : mrd_bank_xbar
// Description : Combinational lane-to-bank routing, lowest lane wins a bank.
// Revision    : 1.0  initial release
// ============================================================================
module mrd_bank_xbar #(
    parameter int wIDX = 3
) (
    input  logic [2:0]        i_factor,
    input  logic [5*wIDX-1:0] i_bank_index,
    output logic [4:0]        o_bank_en,
    output logic [14:0]       o_bank_lane,
    output logic              o_conflict
);
    import mrd_pkg::*;

    logic [2:0]      w_factor;
    logic [wIDX-1:0] w_idx;

    always_comb begin
        w_factor    = (i_factor < 3'd2) ? 3'd2 : ((i_factor > 3'd5) ? 3'd5 : i_factor);
        w_idx       = '0;
        o_bank_en   = '0;
        o_bank_lane = '0;
        o_conflict  = 1'b0;
        // Ascending lane order gives the lower lane priority on a shared bank.
        for (int i = 0; i < NUM_BANK; i++) begin
            w_idx = i_bank_index[i*wIDX +: wIDX];
            if (3'(i) < w_factor) begin
                if (w_idx > wIDX'(NUM_BANK-1)) begin
                    o_conflict = 1'b1;
                end else if (o_bank_en[w_idx]) begin
                    o_conflict = 1'b1;
                end else begin
                    o_bank_en[w_idx]         = 1'b1;
                    o_bank_lane[w_idx*3 +: 3] = 3'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mrd_rdx2345_wr_bank.sv
`default_nettype none
// ============================================================================
// Module      : mrd_rdx2345_wr_bank
// Description : Write-back crossbar and per-stage vector counter after the
//               radix-2/3/4/5 butterfly. Optional headroom: MRD_WR_MARGIN_EN.
// Revision    : 1.0  initial release
// ============================================================================
module mrd_rdx2345_wr_bank #(
    parameter int wDATA = 18,
    parameter int wADDR = 8,
    parameter int wIDX  = 3,
    parameter int wCNT  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sop,
    input  logic [wCNT-1:0]      stage_len,
    input  logic [2:0]           factor,
    input  logic                 in_valid,
    input  logic [5*wDATA-1:0]   in_d_real,
    input  logic [5*wDATA-1:0]   in_d_imag,
    input  logic [5*wIDX-1:0]    in_bank_index,
    input  logic [5*wADDR-1:0]   in_bank_addr,
    input  logic [3:0]           in_exp,
    output logic [4:0]           wr_en,
    output logic [5*wADDR-1:0]   wr_addr,
    output logic [10*wDATA-1:0]  wr_data,
    output logic                 stage_done,
    output logic [3:0]           stage_exp,
    output logic                 busy,
    output logic                 conflict_err,
    output logic                 overrun_err,
    output logic [1:0]           margin_out
);
    import mrd_pkg::*;

    logic [wDATA-1:0] w_lane_re   [NUM_BANK];
    logic [wDATA-1:0] w_lane_im   [NUM_BANK];
    logic [wADDR-1:0] w_lane_addr [NUM_BANK];
    logic [2:0]       w_sel_lane  [NUM_BANK];
    logic [4:0]       w_bank_en;
    logic [14:0]      w_bank_lane;
    logic             w_xbar_conflict;
    logic             w_accept;
    logic             w_conflict;
    logic             w_overrun;

    state_t           r_state;
    logic [wCNT-1:0]  r_cnt;
    logic [wCNT-1:0]  r_len;
    logic             r_first;
    logic [3:0]       r_exp;
    logic             r_busy;
    logic             r_done;
    logic             r_conf;
    logic             r_ovr;
    logic [4:0]       r_wr_en;
    logic [wADDR-1:0] r_addr [NUM_BANK];
    logic [wDATA-1:0] r_re   [NUM_BANK];
    logic [wDATA-1:0] r_im   [NUM_BANK];

    mrd_bank_xbar #(
        .wIDX         (wIDX)
    ) u_xbar (
        .i_factor     (factor),
        .i_bank_index (in_bank_index),
        .o_bank_en    (w_bank_en),
        .o_bank_lane  (w_bank_lane),
        .o_conflict   (w_xbar_conflict)
    );

    for (genvar l = 0; l < NUM_BANK; l++) begin : g_lane
        assign w_lane_re[l]   = in_d_real[l*wDATA +: wDATA];
        assign w_lane_im[l]   = in_d_imag[l*wDATA +: wDATA];
        assign w_lane_addr[l] = in_bank_addr[l*wADDR +: wADDR];
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        assign w_sel_lane[b]                   = w_bank_lane[b*3 +: 3];
        assign wr_addr[b*wADDR +: wADDR]       = r_addr[b];
        assign wr_data[b*2*wDATA +: 2*wDATA]   = {r_re[b], r_im[b]};
    end

    // A vector alongside sop belongs to the new stage unless that stage is empty.
    assign w_accept   = in_valid & (sop ? (stage_len != '0) : (r_state == RUN));
    assign w_conflict = w_accept & w_xbar_conflict;
    assign w_overrun  = in_valid & ~sop & (r_state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_first <= 1'b0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_conf  <= 1'b0;
            r_ovr   <= 1'b0;
            r_wr_en <= '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                r_addr[b] <= '0;
                r_re[b]   <= '0;
                r_im[b]   <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= w_accept ? w_bank_en : 5'd0;
            for (int b = 0; b < NUM_BANK; b++) begin
                if (w_accept && w_bank_en[b]) begin
                    r_addr[b] <= w_lane_addr[w_sel_lane[b]];
                    r_re[b]   <= w_lane_re[w_sel_lane[b]];
                    r_im[b]   <= w_lane_im[w_sel_lane[b]];
                end
            end
            if (sop) begin
                r_len  <= stage_len;
                r_conf <= w_conflict;
                r_ovr  <= 1'b0;
                if (w_accept) begin
                    r_cnt   <= wCNT'(1);
                    r_exp   <= in_exp;
                    r_first <= 1'b0;
                    if (stage_len == wCNT'(1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end else begin
                    r_cnt   <= '0;
                    r_first <= 1'b1;
                    if (stage_len == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
            end else begin
                r_conf <= r_conf | w_conflict;
                r_ovr  <= r_ovr | w_overrun;
                case (r_state)
                    RUN: begin
                        if (in_valid) begin
                            r_cnt <= r_cnt + wCNT'(1);
                            if (r_first) begin
                                r_exp   <= in_exp;
                                r_first <= 1'b0;
                            end
                            if (r_cnt + wCNT'(1) == r_len) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign stage_done   = r_done;
    assign stage_exp    = r_exp;
    assign busy         = r_busy;
    assign conflict_err = r_conf;
    assign overrun_err  = r_ovr;

`ifdef MRD_WR_MARGIN_EN
    logic [1:0] w_bank_mrg [NUM_BANK];
    logic [1:0] w_cyc_min;
    logic [1:0] r_min;
    logic [1:0] r_margin;

    // The most negative code negates to itself; its top bit set maps to level 0.
    function automatic logic [1:0] margin_level(input logic [wDATA-1:0] v);
        logic [wDATA-1:0] mag;
        mag = v[wDATA-1] ? (~v + wDATA'(1)) : v;
        if (mag[wDATA-1] || mag[wDATA-2]) return 2'd0;
        else if (mag[wDATA-3])            return 2'd1;
        else if (mag[wDATA-4])            return 2'd2;
        else                              return 2'd3;
    endfunction

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_mrg
        logic [1:0] w_re_lvl;
        logic [1:0] w_im_lvl;
        assign w_re_lvl      = margin_level(w_lane_re[w_sel_lane[b]]);
        assign w_im_lvl      = margin_level(w_lane_im[w_sel_lane[b]]);
        assign w_bank_mrg[b] = (w_re_lvl < w_im_lvl) ? w_re_lvl : w_im_lvl;
    end

    always_comb begin
        w_cyc_min = 2'd3;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (w_accept && w_bank_en[b] && (w_bank_mrg[b] < w_cyc_min)) begin
                w_cyc_min = w_bank_mrg[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min    <= 2'd3;
            r_margin <= 2'd0;
        end else begin
            if (sop) begin
                r_min <= w_cyc_min;
            end else if (w_cyc_min < r_min) begin
                r_min <= w_cyc_min;
            end
            if ((r_state == DONE) && !sop) begin
                r_margin <= r_min;
            end
        end
    end

    assign margin_out = r_margin;
`else
    assign margin_out = 2'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mrd_rdx2345_wr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mrd_rdx2345_wr_bank
// Description : Directed self-checking bench for mrd_rdx2345_wr_bank.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mrd_rdx2345_wr_bank;

    localparam int W = 18;
    localparam int A = 8;
    localparam int I = 3;
    localparam int C = 12;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           sop;
    logic [C-1:0]   stage_len;
    logic [2:0]     factor;
    logic           in_valid;
    logic [5*W-1:0] in_d_real;
    logic [5*W-1:0] in_d_imag;
    logic [5*I-1:0] in_bank_index;
    logic [5*A-1:0] in_bank_addr;
    logic [3:0]     in_exp;
    logic [4:0]     wr_en;
    logic [5*A-1:0] wr_addr;
    logic [10*W-1:0] wr_data;
    logic           stage_done;
    logic [3:0]     stage_exp;
    logic           busy;
    logic           conflict_err;
    logic           overrun_err;
    logic [1:0]     margin_out;

    int checks = 0;
    int errors = 0;

    mrd_rdx2345_wr_bank #(
        .wDATA(W), .wADDR(A), .wIDX(I), .wCNT(C)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sop           (sop),
        .stage_len     (stage_len),
        .factor        (factor),
        .in_valid      (in_valid),
        .in_d_real     (in_d_real),
        .in_d_imag     (in_d_imag),
        .in_bank_index (in_bank_index),
        .in_bank_addr  (in_bank_addr),
        .in_exp        (in_exp),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .stage_done    (stage_done),
        .stage_exp     (stage_exp),
        .busy          (busy),
        .conflict_err  (conflict_err),
        .overrun_err   (overrun_err),
        .margin_out    (margin_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] dre(input int lane, input int k);
        return W'(k*256 + lane*16 + 1);
    endfunction

    function automatic logic [W-1:0] dim(input int lane, input int k);
        return W'(-(k*256 + lane*16 + 1));
    endfunction

    task automatic set_lane(input int i, input int idx, input int addr, input int k);
        in_bank_index[i*I +: I] = I'(idx);
        in_bank_addr[i*A +: A]  = A'(addr);
        in_d_real[i*W +: W]     = dre(i, k);
        in_d_imag[i*W +: W]     = dim(i, k);
    endtask

    function automatic logic [2*W-1:0] bank_word(input int b);
        return wr_data[b*2*W +: 2*W];
    endfunction

    function automatic logic [A-1:0] bank_addr(input int b);
        return wr_addr[b*A +: A];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sop = 1'b0; stage_len = '0; factor = 3'd5; in_valid = 1'b0;
        in_d_real = '0; in_d_imag = '0; in_bank_index = '0; in_bank_addr = '0; in_exp = '0;
        tick(); tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", stage_done, 0);
        chk("rst_exp", stage_exp, 0);
        chk("rst_errs", {conflict_err, overrun_err}, 0);
        chk("rst_addr_data", {wr_addr, wr_data}, 0);
        rst_n = 1'b1;
        tick();

        // Stage of three full radix-5 vectors
        sop = 1'b1; stage_len = 12'd3;
        tick();
        sop = 1'b0;
        chk("t1_busy_run", busy, 1);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) set_lane(i, i, i*10, k);
            factor = 3'd5; in_valid = 1'b1; in_exp = (k == 0) ? 4'd3 : 4'd5;
            tick();
            chk($sformatf("t1_wr_en_%0d", k), wr_en, 5'b11111);
            for (int b = 0; b < 5; b++) begin
                chk($sformatf("t1_addr_b%0d_k%0d", b, k), bank_addr(b), b*10);
                chk($sformatf("t1_data_b%0d_k%0d", b, k), bank_word(b), {dre(b, k), dim(b, k)});
            end
            chk($sformatf("t1_done_early_%0d", k), stage_done, 0);
        end
        chk("t1_busy_after_last", busy, 0);
        in_valid = 1'b0;
        tick();
        chk("t1_done", stage_done, 1);
        chk("t1_wr_en_idle", wr_en, 0);
        chk("t1_exp", stage_exp, 3);
        chk("t1_busy_done", busy, 0);
        chk("t1_conflict", conflict_err, 0);
        tick();
        chk("t1_done_one_cycle", stage_done, 0);

        // Radix-3 with garbage on inactive lanes, then a radix-4 conflict
        sop = 1'b1; stage_len = 12'd2;
        tick();
        sop = 1'b0;
        factor = 3'd3; in_exp = 4'd6; in_valid = 1'b1;
        set_lane(0, 4, 1, 3); set_lane(1, 0, 11, 3); set_lane(2, 2, 21, 3);
        set_lane(3, 1, 31, 3); set_lane(4, 1, 41, 3);
        tick();
        chk("t2_wr_en", wr_en, 5'b10101);
        chk("t2_addr_b4", bank_addr(4), 1);
        chk("t2_data_b0", bank_word(0), {dre(1, 3), dim(1, 3)});
        chk("t2_hold_addr_b3", bank_addr(3), 30);
        chk("t2_hold_data_b3", bank_word(3), {dre(3, 2), dim(3, 2)});
        chk("t2_conflict_clear", conflict_err, 0);
        factor = 3'd4; in_exp = 4'd7;
        set_lane(0, 2, 2, 4); set_lane(1, 2, 12, 4); set_lane(2, 0, 22, 4); set_lane(3, 1, 32, 4);
        tick();
        chk("t2_conf_wr_en", wr_en, 5'b00111);
        chk("t2_conf_b2", bank_word(2), {dre(0, 4), dim(0, 4)});
        chk("t2_conf_b2_addr", bank_addr(2), 2);
        chk("t2_conf_b0", bank_word(0), {dre(2, 4), dim(2, 4)});
        chk("t2_conflict_set", conflict_err, 1);
        in_valid = 1'b0;
        tick();
        chk("t2_done", stage_done, 1);
        chk("t2_exp", stage_exp, 6);
        chk("t2_conflict_sticky", conflict_err, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ovr_wr_en", wr_en, 0);
        chk("ovr_flag", overrun_err, 1);
        chk("ovr_exp_hold", stage_exp, 6);

        // sop and in_valid in the same cycle, single-vector stage
        sop = 1'b1; stage_len = 12'd1; in_valid = 1'b1; factor = 3'd2; in_exp = 4'd9;
        set_lane(0, 3, 50, 6); set_lane(1, 1, 60, 6);
        tick();
        sop = 1'b0; in_valid = 1'b0;
        chk("t3_wr_en", wr_en, 5'b01010);
        chk("t3_data_b3", bank_word(3), {dre(0, 6), dim(0, 6)});
        chk("t3_errs_cleared", {conflict_err, overrun_err}, 0);
        chk("t3_exp", stage_exp, 9);
        chk("t3_done_early", stage_done, 0);
        tick();
        chk("t3_done", stage_done, 1);

        // Illegal bank index on an active lane
        sop = 1'b1; stage_len = 12'd1;
        tick();
        sop = 1'b0; in_valid = 1'b1; factor = 3'd2;
        set_lane(0, 5, 70, 7); set_lane(1, 0, 80, 7);
        tick();
        in_valid = 1'b0;
        chk("ill_wr_en", wr_en, 5'b00001);
        chk("ill_data_b0", bank_word(0), {dre(1, 7), dim(1, 7)});
        chk("ill_conflict", conflict_err, 1);
        tick();
        chk("ill_done", stage_done, 1);

        // Empty stage
        sop = 1'b1; stage_len = 12'd0;
        tick();
        sop = 1'b0;
        chk("zero_done_early", stage_done, 0);
        chk("zero_busy", busy, 0);
        chk("zero_conf_cleared", conflict_err, 0);
        tick();
        chk("zero_done", stage_done, 1);
        chk("zero_wr_en", wr_en, 0);
        tick();
        chk("zero_done_one_cycle", stage_done, 0);

        // sop while DONE suppresses the pending pulse
        sop = 1'b1; stage_len = 12'd1; in_valid = 1'b1; factor = 3'd2;
        set_lane(0, 0, 5, 8); set_lane(1, 1, 6, 8);
        tick();
        stage_len = 12'd2; in_valid = 1'b0;
        tick();
        sop = 1'b0;
        chk("sup_done", stage_done, 0);
        chk("sup_busy", busy, 1);
        tick();
        chk("sup_done_late", stage_done, 0);

        // Asynchronous reset in the middle of a stage
        in_valid = 1'b1;
        tick();
        chk("mid_wr_en", wr_en, 5'b00011);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", {stage_exp, conflict_err, overrun_err, stage_done, margin_out}, 0);
        chk("mid_rst_data", wr_data, 0);
        tick(); tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("mid_rst_no_done", stage_done, 0);
        tick();
        chk("mid_rst_no_done2", stage_done, 0);

`ifdef MRD_WR_MARGIN_EN
        sop = 1'b1; stage_len = 12'd1;
        tick();
        sop = 1'b0; in_valid = 1'b1; factor = 3'd2;
        in_bank_index[0 +: 3] = 3'd0; in_bank_index[3 +: 3] = 3'd1;
        in_d_real[0 +: W] = W'(1 << 14); in_d_imag[0 +: W] = W'(-100);
        in_d_real[W +: W] = W'(3);       in_d_imag[W +: W] = W'(-7);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mrg_done", stage_done, 1);
        chk("mrg_2", margin_out, 2);
        sop = 1'b1; stage_len = 12'd1;
        tick();
        sop = 1'b0; in_valid = 1'b1;
        in_d_real[0 +: W] = W'(5); in_d_imag[0 +: W] = W'(-(1 << 17));
        tick();
        in_valid = 1'b0;
        chk("mrg_hold", margin_out, 2);
        tick();
        chk("mrg_0", margin_out, 0);
`else
        chk("mrg_tied", margin_out, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
